// File: rtl/rsa4k_decrypt_pkg.sv
// Shared definitions for the RSA private-key datapath: controller state
// encodings and the opcode telling the modular multiplier what to compute.
package rsa4k_decrypt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_MUL   = 3'd2,
    ST_SQR   = 3'd3,
    ST_FIN   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // MM_MUL: acc * base mod n; MM_SQR: base * base mod n
  typedef enum logic {
    MM_MUL = 1'b0,
    MM_SQR = 1'b1
  } mm_op_t;

endpackage

// File: rtl/rsa4k_decrypt_modmul_serial.sv
// Bit-serial interleaved modular multiplier: result = a * b mod n.
// a is scanned MSB first, one bit per cycle. A start in cycle t yields a
// one-cycle mm_done pulse in cycle t+WIDTH with result valid.
// Operands must satisfy a, b < n.
module modmul_serial #(
  parameter int WIDTH = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] result,
  output logic             mm_done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] n_r;
  logic [WIDTH+1:0] r;
  logic [CW-1:0]    cnt;
  logic             busy;

  // One interleaved step: r = 2r + (bit ? b : 0), then reduce below n.
  // With r, b < n the sum stays below 3n, so two subtractions suffice and
  // WIDTH+2 bits cannot overflow.
  function automatic logic [WIDTH+1:0] mm_step(
    input logic [WIDTH+1:0] r_in,
    input logic             bit_in,
    input logic [WIDTH-1:0] b_in,
    input logic [WIDTH-1:0] n_in
  );
    logic [WIDTH+1:0] t;
    logic [WIDTH+1:0] nx;
    nx = {2'b00, n_in};
    t  = (r_in << 1) + (bit_in ? {2'b00, b_in} : '0);
    if (t >= nx) t = t - nx;
    if (t >= nx) t = t - nx;
    return t;
  endfunction

  // Control: step counter and completion pulse; reset aborts a running product
  always_ff @(posedge clk) begin
    if (reset) begin
      busy    <= 1'b0;
      mm_done <= 1'b0;
      cnt     <= '0;
    end else begin
      mm_done <= 1'b0;
      if (start) begin
        busy <= 1'b1;
        cnt  <= CW'(WIDTH - 1);
      end else if (busy) begin
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          busy    <= 1'b0;
          mm_done <= 1'b1;
        end
      end
    end
  end

  // Data: the first bit is consumed on the start edge so the last lands in time
  always_ff @(posedge clk) begin
    if (start) begin
      r    <= mm_step('0, a[WIDTH-1], b, n);
      a_sh <= {a[WIDTH-2:0], 1'b0};
      b_r  <= b;
      n_r  <= n;
    end else if (busy) begin
      r    <= mm_step(r, a_sh[WIDTH-1], b_r, n_r);
      a_sh <= {a_sh[WIDTH-2:0], 1'b0};
    end
  end

  assign result = r[WIDTH-1:0];

endmodule

// File: rtl/rsa4k_decrypt.sv
// RSA private-key operation: message = cypher^priv_exp mod modulus using
// right-to-left square-and-multiply over one serial modular multiplier.
// go/done is a 4-phase level handshake; operands are captured when go is
// accepted in IDLE and later input changes are ignored.
module rsa4k_decrypt #(
  parameter int WIDTH = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] cypher,
  input  logic [WIDTH-1:0] priv_exp,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] message,
  output logic             done,
  output logic             err
);

  import rsa4k_decrypt_pkg::*;

  state_t           state_q;
  state_t           state_d;
  mm_op_t           op_q;
  mm_op_t           op_d;
  logic             issue;
  logic             mm_start;
  logic             mm_done;
  logic [WIDTH-1:0] mm_res;
  logic [WIDTH-1:0] mm_a;

  logic [WIDTH-1:0] c_r;
  logic [WIDTH-1:0] d_r;
  logic [WIDTH-1:0] n_r;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] e;

  logic             chk_ok;
  logic [WIDTH-1:0] acc_init;

  // Operand sanity and the starting accumulator (x^0 mod 1 is 0, not 1)
  assign chk_ok   = (n_r != '0) && (c_r < n_r);
  assign acc_init = (n_r == WIDTH'(1)) ? '0 : WIDTH'(1);

  // Squaring always uses base for both operands; multiply uses acc * base
  assign mm_a = (op_q == MM_SQR) ? base : acc;

  modmul_serial #(.WIDTH(WIDTH)) u_mm (
    .clk     (clk),
    .reset   (reset),
    .start   (mm_start),
    .a       (mm_a),
    .b       (base),
    .n       (n_r),
    .result  (mm_res),
    .mm_done (mm_done)
  );

  // Next-state logic; a product is issued on entry to MUL/SQR so skipped
  // multiplies and the final exponent test cost no extra cycles
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    op_d    = MM_MUL;
    case (state_q)
      ST_IDLE: begin
        if (go) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (!chk_ok || d_r == '0) begin
          state_d = ST_DONE;
        end else if (d_r[0]) begin
          state_d = ST_MUL;
          issue   = 1'b1;
          op_d    = MM_MUL;
        end else begin
          state_d = ST_SQR;
          issue   = 1'b1;
          op_d    = MM_SQR;
        end
      end
      ST_MUL: begin
        if (mm_done) begin
          if ((e >> 1) == '0) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_SQR;
            issue   = 1'b1;
            op_d    = MM_SQR;
          end
        end
      end
      ST_SQR: begin
        // e is nonzero after the shift, so a clear next bit means another square
        if (mm_done) begin
          if (e[1]) begin
            state_d = ST_MUL;
            issue   = 1'b1;
            op_d    = MM_MUL;
          end else begin
            state_d = ST_SQR;
            issue   = 1'b1;
            op_d    = MM_SQR;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!go) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register and host-visible outputs; reset discards any operation
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      mm_start <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      message  <= '0;
    end else begin
      state_q  <= state_d;
      mm_start <= issue;
      done     <= (state_d == ST_DONE);
      if (state_q == ST_CHECK && state_d == ST_DONE) begin
        err     <= !chk_ok;
        message <= chk_ok ? acc_init : '0;
      end
      if (state_q == ST_FIN) message <= acc;
      if (state_q == ST_DONE && !go) err <= 1'b0;
    end
  end

  // Operand capture and exponentiation working registers
  always_ff @(posedge clk) begin
    op_q <= op_d;
    if (state_q == ST_IDLE && go) begin
      c_r <= cypher;
      d_r <= priv_exp;
      n_r <= modulus;
    end
    if (state_q == ST_CHECK) begin
      acc  <= acc_init;
      base <= c_r;
      e    <= d_r;
    end
    if (mm_done && state_q == ST_MUL) acc <= mm_res;
    if (mm_done && state_q == ST_SQR) begin
      base <= mm_res;
      e    <= e >> 1;
    end
  end

endmodule

// File: tb/tb_rsa4k_decrypt.sv
// Bench for rsa4k_decrypt at WIDTH=16: vector table plus handshake, reset
// and input-change sequences, with a queue scoreboard of expected results.
`timescale 1ns/1ps
module tb_rsa4k_decrypt;

  localparam int W   = 16;
  localparam int TMO = 5000;

  logic         clk = 1'b0;
  logic         reset;
  logic         go;
  logic [W-1:0] cypher;
  logic [W-1:0] priv_exp;
  logic [W-1:0] modulus;
  logic [W-1:0] message;
  logic         done;
  logic         err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [W-1:0] c;
    logic [W-1:0] d;
    logic [W-1:0] n;
    logic [W-1:0] msg;
    logic         err;
  } vec_t;

  typedef struct {
    logic [W-1:0] msg;
    logic         err;
    int           lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];

  rsa4k_decrypt #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .go       (go),
    .cypher   (cypher),
    .priv_exp (priv_exp),
    .modulus  (modulus),
    .message  (message),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Left-to-right exponentiation on 64-bit integers (n must be nonzero)
  function automatic logic [W-1:0] model(input logic [W-1:0] c, input logic [W-1:0] d,
                                         input logic [W-1:0] n);
    logic [63:0] r, b, m;
    m = {48'd0, n};
    b = {48'd0, c};
    r = 64'd1 % m;
    for (int i = W - 1; i >= 0; i--) begin
      r = (r * r) % m;
      if (d[i]) r = (r * b) % m;
    end
    return r[W-1:0];
  endfunction

  function automatic int lat_of(input logic [W-1:0] c, input logic [W-1:0] d,
                                input logic [W-1:0] n);
    int len = 0;
    int pop = 0;
    if (n == '0 || c >= n || d == '0) return 2;
    for (int i = 0; i < W; i++) begin
      if (d[i]) begin
        len = i + 1;
        pop++;
      end
    end
    return 2 + (len - 1) * (W + 1) + pop * (W + 1) + 1;
  endfunction

  function automatic vec_t mk(input logic [W-1:0] c, input logic [W-1:0] d,
                              input logic [W-1:0] n, input logic [W-1:0] msg, input logic e);
    vec_t v;
    v.c = c; v.d = d; v.n = n; v.msg = msg; v.err = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, expv);
    end
  endtask

  task automatic check_int(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, expv);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    go    = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Issue one request, wait for done, score it, hold go for 'hold' cycles,
  // then complete the handshake. 'scramble' changes the inputs mid-run.
  task automatic run_op(input vec_t v, input bit scramble, input int hold);
    exp_t x;
    exp_t got;
    int   cyc;
    int   bad;
    bit   seen;
    x.msg = v.msg;
    x.err = v.err;
    x.lat = lat_of(v.c, v.d, v.n);
    @(negedge clk);
    cypher   = v.c;
    priv_exp = v.d;
    modulus  = v.n;
    go       = 1'b1;
    sb.push_back(x);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < TMO) begin
      @(posedge clk);
      #1;
      cyc++;
      if (scramble && cyc == 3) begin
        cypher   = W'($urandom);
        priv_exp = W'($urandom);
        modulus  = W'($urandom);
      end
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      check("done_timeout", W'(0), W'(1));
      sb.delete();
      do_reset();
      return;
    end
    if (sb.size() == 0) begin
      check("sb_empty", W'(0), W'(1));
      return;
    end
    got = sb.pop_front();
    check("message", message, got.msg);
    check("err", W'(err), W'(got.err));
    check_int("latency", cyc, got.lat);
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b1 || message !== got.msg || err !== got.err) bad++;
    end
    if (hold > 0) check_int("hold_go_stable", bad, 0);
    @(negedge clk);
    go = 1'b0;
    @(posedge clk);
    #1;
    check("done_clear", W'(done), W'(0));
    check("err_clear", W'(err), W'(0));
    check("msg_retained", message, got.msg);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] c_enc;
    logic [W-1:0] rn, rc, rd;
    int           bad;

    reset    = 1'b1;
    go       = 1'b0;
    cypher   = '0;
    priv_exp = '0;
    modulus  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_done", W'(done), W'(0));
    check("reset_err", W'(err), W'(0));
    check("reset_msg", message, W'(0));
    @(negedge clk);
    reset = 1'b0;

    // Vector table
    c_enc = model(W'(8), W'(13), W'(77));
    vecs.push_back(mk(W'(50), W'(37), W'(77), W'(8), 1'b0));
    vecs.push_back(mk(c_enc, W'(37), W'(77), W'(8), 1'b0));
    vecs.push_back(mk(W'(5), W'(0), W'(77), W'(1), 1'b0));
    vecs.push_back(mk(W'(0), W'(9), W'(1), W'(0), 1'b0));
    vecs.push_back(mk(W'(77), W'(5), W'(77), W'(0), 1'b1));
    vecs.push_back(mk(W'(5), W'(5), W'(0), W'(0), 1'b1));
    vecs.push_back(mk(W'(76), W'(1), W'(77), W'(76), 1'b0));
    vecs.push_back(mk(W'(2), W'(16'h8000), W'(65521), model(W'(2), W'(16'h8000), W'(65521)), 1'b0));
    for (int i = 0; i < 3; i++) begin
      rn = W'($urandom_range(3, 65535)) | W'(1);
      rc = W'($urandom % rn);
      rd = W'($urandom);
      vecs.push_back(mk(rc, rd, rn, model(rc, rd, rn), 1'b0));
    end
    foreach (vecs[i]) run_op(vecs[i], 1'b0, 0);

    // go held long after done, then a fresh request
    run_op(mk(W'(50), W'(37), W'(77), W'(8), 1'b0), 1'b0, 50);
    run_op(mk(W'(64), W'(37), W'(77), model(W'(64), W'(37), W'(77)), 1'b0), 1'b0, 0);

    // Reset in the middle of the first squaring
    @(negedge clk);
    cypher   = W'(50);
    priv_exp = W'(37);
    modulus  = W'(77);
    go       = 1'b1;
    repeat (25) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_done", W'(done), W'(0));
    check("midreset_err", W'(err), W'(0));
    check("midreset_msg", message, W'(0));
    @(negedge clk);
    reset = 1'b0;
    go    = 1'b0;
    bad   = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || message !== '0) bad++;
    end
    check_int("midreset_quiet", bad, 0);
    run_op(mk(W'(50), W'(37), W'(77), W'(8), 1'b0), 1'b0, 0);

    // Inputs changed while busy must not disturb the result
    run_op(mk(W'(50), W'(37), W'(77), W'(8), 1'b0), 1'b1, 0);
    run_op(mk(W'(64), W'(37), W'(77), model(W'(64), W'(37), W'(77)), 1'b0), 1'b1, 0);

    check_int("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
